// File: rtl/video_fetch_pkg.sv
// video_fetch_pkg: shared mode codes, read-tag layout and sequencer states for the video fetch path.
package video_fetch_pkg;

    typedef enum logic [1:0] {
        VM_ZX   = 2'd0,
        VM_16C  = 2'd1,
        VM_256C = 2'd2,
        VM_OFF  = 2'd3
    } vmode_t;

    typedef struct packed {
        logic [3:0] f_sel;
        logic [1:0] b_sel;
    } tag_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ0 = 2'd1,
        S_REQ1 = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Byte-lane routing for the first or second read of a period; lsb is the source pointer's bit 0.
    function automatic tag_t make_tag(vmode_t m, logic second, logic lsb);
        if (m == VM_ZX)
            return second ? tag_t'{4'b0010, {lsb, 1'b0}} : tag_t'{4'b0001, {1'b0, lsb}};
        return second ? tag_t'{4'b1100, 2'b00} : tag_t'{4'b0011, 2'b10};
    endfunction

endpackage

// File: rtl/video_fetch_tagq.sv
// video_fetch_tagq: in-order FIFO of outstanding read tags; the head is read straight from
// registered storage and forced to zero while empty.
module video_fetch_tagq
    import video_fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  tag_t din,
    input  logic pop,
    output logic full,
    output logic empty,
    output tag_t head
);

    localparam int AW = $clog2(DEPTH);

    tag_t           mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    cnt;
    logic           do_push;
    logic           do_pop;

    assign full    = cnt == (AW+1)'(DEPTH);
    assign empty   = cnt == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/video_fetch_ctrl.sv
// video_fetch_ctrl: per-period sequencer issuing the mode's DRAM reads, tagging each with its
// byte-lane routing and pulsing fetch_stb/underrun one clock after every fetch_go.
module video_fetch_ctrl
    import video_fetch_pkg::*;
#(
    parameter int TAG_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        line_start,
    input  logic        fetch_go,
    input  logic [1:0]  mode,
    input  logic [21:0] pix_base,
    input  logic [21:0] attr_base,
    output logic        video_req,
    output logic [20:0] video_addr,
    input  logic        video_next,
    input  logic        video_strobe,
    output logic [3:0]  f_sel,
    output logic [1:0]  b_sel,
    output logic        fetch_stb,
    output logic        underrun
);

    state_t      state;
    vmode_t      mode_q;
    logic [21:0] pix_ptr;
    logic [21:0] attr_ptr;
    logic [20:0] pix_r1;
    logic        zx;
    logic        busy;
    logic        acc;
    logic        step;
    logic        full;
    logic        empty;
    tag_t        push_tag;
    tag_t        head;

    assign zx       = mode_q == VM_ZX;
    assign busy     = state == S_REQ0 || state == S_REQ1;
    assign pix_r1   = pix_ptr[21:1] + 21'd1;
    assign video_req = busy && !full;
    assign acc      = video_req && video_next;
    assign video_addr = state == S_REQ1 ? (zx ? attr_ptr[21:1] : pix_r1) : pix_ptr[21:1];
    assign push_tag = make_tag(mode_q, state == S_REQ1, state == S_REQ1 ? attr_ptr[0] : pix_ptr[0]);
    // An abandoned period still advances the pointers so the display position stays in step.
    assign step     = fetch_go ? busy : (state == S_REQ1 && acc);
    assign f_sel    = head.f_sel;
    assign b_sel    = head.b_sel;

    video_fetch_tagq #(.DEPTH(TAG_DEPTH)) u_tagq (
        .clk   (clk),
        .rst   (rst),
        .push  (acc),
        .din   (push_tag),
        .pop   (video_strobe),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            mode_q    <= VM_ZX;
            pix_ptr   <= '0;
            attr_ptr  <= '0;
            fetch_stb <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            fetch_stb <= fetch_go;
            underrun  <= fetch_go && (busy || !empty);
            if (line_start) begin
                pix_ptr  <= pix_base;
                attr_ptr <= attr_base;
            end else if (step) begin
                pix_ptr <= pix_ptr + (zx ? 22'd1 : 22'd4);
                if (zx) attr_ptr <= attr_ptr + 22'd1;
            end
            if (fetch_go) begin
                mode_q <= vmode_t'(mode);
                state  <= mode == VM_OFF ? S_DONE : S_REQ0;
            end else if (acc) begin
                state <= state == S_REQ0 ? S_REQ1 : S_DONE;
            end
        end
    end

endmodule
